// File: rtl/my_bus_pkg.sv
// ============================================================================
//  Module      : my_bus_pkg
//  Description : Shared types, opcodes and address decode for the bus slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_bus_pkg;

  localparam logic WRITE_OP = 1'b1;
  localparam logic READ_OP  = 1'b0;

  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic                  vld;
    logic                  okay;
    logic [RSP_DATA_W-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] idx;
  } dec_t;

  // Offset wraps in addr_w bits; the access is legal only when it lands on an
  // aligned word inside the array.
  function automatic dec_t addr_decode(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int          addr_w,
                                       input int          lsb,
                                       input int          depth);
    logic [63:0] mask;
    logic [63:0] off;
    dec_t        d;
    mask    = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
    off     = (addr - base) & mask;
    d.idx   = off[31+lsb -: 32];
    d.legal = (addr >= base) &&
              ((off & ((64'd1 << lsb) - 64'd1)) == 64'd0) &&
              ((off >> lsb) < 64'(depth));
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_bus_rsp_pipe.sv
// ============================================================================
//  Module      : my_bus_rsp_pipe
//  Description : RSP_LAT-stage shift register of {vld, okay, rdata}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_bus_rsp_pipe #(
  parameter int RSP_LAT = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic              i_okay,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_vld,
  output logic              o_okay,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W+1:0] r_stage [RSP_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RSP_LAT; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= {i_vld, i_okay, i_rdata};
      for (int s = 1; s < RSP_LAT; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign {o_vld, o_okay, o_rdata} = r_stage[RSP_LAT-1];

endmodule

`default_nettype wire

// File: rtl/my_bus_mem_slave.sv
// ============================================================================
//  Module      : my_bus_mem_slave
//  Description : Memory-backed bus slave with byte strobes, error responses
//                and configurable response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_bus_mem_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000,
  parameter int                RSP_LAT   = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SEL,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] STRB,
  output logic                RSP_VLD,
  output logic [DATA_W-1:0]   RDATA,
  output logic                OKAY
);

  import my_bus_pkg::*;

  localparam int c_NB    = DATA_W / 8;
  localparam int c_LSB   = $clog2(c_NB);
  localparam int c_IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  dec_t               w_dec;
  logic               w_legal;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_ok;
  logic [DATA_W-1:0]  w_rdata;

  always_comb begin
    w_dec   = addr_decode(64'(ADDR), 64'(BASE_ADDR), ADDR_W, c_LSB, DEPTH);
    w_idx   = w_dec.idx[c_IDX_W-1:0];
    w_legal = w_dec.legal && ((w_dec.idx >> c_IDX_W) == 32'd0);
    w_ok    = SEL && w_legal;
    // Read data is sampled before this edge's write lands: snapshot semantics.
    w_rdata = (w_ok && (WRITE == READ_OP)) ? r_mem[w_idx] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
    end else if (w_ok && (WRITE == WRITE_OP)) begin
      for (int b = 0; b < c_NB; b++) begin
        if (STRB[b]) r_mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  my_bus_rsp_pipe #(
    .RSP_LAT (RSP_LAT),
    .DATA_W  (DATA_W)
  ) u_rsp_pipe (
    .clk     (CLK),
    .rst     (RST),
    .i_vld   (SEL),
    .i_okay  (w_ok),
    .i_rdata (w_rdata),
    .o_vld   (RSP_VLD),
    .o_okay  (OKAY),
    .o_rdata (RDATA)
  );

endmodule

`default_nettype wire

// File: tb/tb_my_bus_mem_slave.sv
// ============================================================================
//  Module      : tb_my_bus_mem_slave
//  Description : Drives a latency-2 and a latency-1 slave with one request
//                stream and compares both against a word-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_bus_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb  = '0;

  logic        vld2, okay2, vld1, okay1;
  logic [31:0] rdata2, rdata1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [16];
  logic [33:0] prev_rsp = '0;

  always #5 clk = ~clk;

  my_bus_mem_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h1000), .RSP_LAT(2)
  ) u_dut2 (
    .CLK(clk), .RST(rst), .SEL(sel), .WRITE(wr), .ADDR(addr), .WDATA(wdata),
    .STRB(strb), .RSP_VLD(vld2), .RDATA(rdata2), .OKAY(okay2)
  );

  my_bus_mem_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h1000), .RSP_LAT(1)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .SEL(sel), .WRITE(wr), .ADDR(addr), .WDATA(wdata),
    .STRB(strb), .RSP_VLD(vld1), .RDATA(rdata1), .OKAY(okay1)
  );

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got vld/okay/rdata=%0b/%0b/%08h, want %0b/%0b/%08h",
               tag, obs[33], obs[32], obs[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Expected response of one request, updating the model memory afterwards.
  function automatic logic [33:0] model_req(input logic r, input logic s, input logic w,
                                            input logic [31:0] a, input logic [31:0] d,
                                            input logic [3:0] st);
    logic [31:0] off;
    logic        legal;
    logic [33:0] rsp;
    if (r) begin
      for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
      return '0;
    end
    if (!s) return '0;
    off   = a - 32'h1000;
    legal = (a >= 32'h1000) && (off % 4 == 0) && (off / 4 < 16);
    if (!legal) return {1'b1, 1'b0, 32'h0};
    rsp = {1'b1, 1'b1, (w ? 32'h0 : mdl_mem[off/4])};
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl_mem[off/4][8*b +: 8] = d[8*b +: 8];
    end
    return rsp;
  endfunction

  task automatic step(input string tag, input logic r, input logic s, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [33:0] rsp;
    @(negedge clk);
    rst = r; sel = s; wr = w; addr = a; wdata = d; strb = st;
    rsp = model_req(r, s, w, a, d, st);
    @(posedge clk);
    #1;
    chk({tag, "/lat1"}, {vld1, okay1, rdata1}, rsp);
    chk({tag, "/lat2"}, {vld2, okay2, rdata2}, r ? 34'h0 : prev_rsp);
    prev_rsp = rsp;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0, 1, 2: a = 32'h1000 + 4 * $urandom_range(0, 15);
      3:       a = 32'h1000 - 4 * $urandom_range(1, 8);
      4:       a = 32'h1040 + 4 * $urandom_range(0, 8);
      5:       a = 32'h1000 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      default: a = 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) step("reset", 1, 1, 1, 32'h1004, 32'hFFFF_FFFF, 4'hF);
    step("rd_after_reset", 0, 1, 0, 32'h1004, 0, 0);
    step("strb_wr", 0, 1, 1, 32'h1008, 32'hAABBCCDD, 4'b0101);
    step("strb_rd", 0, 1, 0, 32'h1008, 0, 0);
    step("snap_rd0", 0, 1, 0, 32'h100C, 0, 0);
    step("snap_wr", 0, 1, 1, 32'h100C, 32'h12345678, 4'hF);
    step("snap_rd1", 0, 1, 0, 32'h100C, 0, 0);
    step("err_below", 0, 1, 0, 32'h0FFC, 0, 0);
    step("err_beyond", 0, 1, 0, 32'h1040, 0, 0);
    step("err_misal", 0, 1, 0, 32'h1002, 0, 0);
    step("err_wr", 0, 1, 1, 32'h1040, 32'hDEADBEEF, 4'hF);
    step("word15", 0, 1, 0, 32'h103C, 0, 0);
    step("flight_rd", 0, 1, 0, 32'h1008, 0, 0);
    step("flight_rst", 1, 0, 0, 0, 0, 0);
    step("flight_idle", 0, 0, 0, 0, 0, 0);
    step("flight_idle2", 0, 0, 0, 0, 0, 0);
    step("cafe_wr", 0, 1, 1, 32'h1000, 32'hCAFEF00D, 4'hF);
    step("cafe_rd", 0, 1, 0, 32'h1000, 0, 0);
    step("zero_strb", 0, 1, 1, 32'h1000, 32'h0, 4'h0);
    step("zero_strb_rd", 0, 1, 0, 32'h1000, 0, 0);
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    end
    step("drain", 0, 0, 0, 0, 0, 0);
    step("drain", 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
